// File: rtl/jt6295_decim.sv
// Box-car decimator: averages N = 2^LOG2N signed samples into one output.
// Define JT6295_DECIM_RND_EN for round-half-up instead of floor.
module jt6295_decim #(
    parameter int DW    = 14,
    parameter int LOG2N = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    din_valid,
    input  logic signed [DW-1:0]    din,
    input  logic                    sync,
    output logic signed [DW-1:0]    dout,
    output logic                    dout_valid,
    output logic [LOG2N-1:0]        phase
);

    localparam int AW = DW + LOG2N + 1;

    logic signed [AW-1:0] r_acc;
    logic [LOG2N-1:0]     r_phase;
    logic signed [DW-1:0] r_dout;
    logic                 r_dout_valid;

    logic                 w_sync;
    logic                 w_first;
    logic                 w_last;
    logic signed [AW-1:0] w_din;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_fin;
    logic signed [DW-1:0] w_avg;

    // A sync landing on the output strobe is dropped; phase is already 0 there
    assign w_sync  = sync & ~r_dout_valid;
    assign w_first = w_sync | (r_phase == '0);
    assign w_last  = ~w_sync & (&r_phase);
    assign w_din   = {{(LOG2N+1){din[DW-1]}}, din};
    assign w_sum   = w_first ? w_din : r_acc + w_din;

`ifdef JT6295_DECIM_RND_EN
    localparam logic signed [AW-1:0] RND = AW'(1) <<< (LOG2N - 1);
    assign w_fin = w_sum + RND;
`else
    assign w_fin = w_sum;
`endif

    // Arithmetic shift right by LOG2N, keeping the low DW bits
    assign w_avg = w_fin[DW+LOG2N-1:LOG2N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_phase      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (din_valid) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_phase      <= '0;
                    r_dout       <= w_avg;
                    r_dout_valid <= 1'b1;
                end else if (w_sync) begin
                    r_phase <= LOG2N'(1);
                end else begin
                    r_phase <= r_phase + LOG2N'(1);
                end
            end else if (w_sync) begin
                r_acc   <= '0;
                r_phase <= '0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign phase      = r_phase;

endmodule
